lut_config_loader: RTL and testbench

- Upstream configuration stage for the SLICEM bit-writable LUT latch blocks.
- Deserializes a ready/valid-handshaked serial configuration bitstream into MEM_SIZE-bit words.
- Delivers each word to one of NUM_LUTS latch blocks. Each delivery is a one-cycle, one-hot cen pulse with the word held stable on config_out.
- Asserts done once every LUT has been loaded.

---
 rtl/lut_config_loader_if.sv | 20 ++
 rtl/lut_config_loader.sv | 147 ++++++++++++++
 tb/tb_lut_config_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_config_loader_if.sv
// Serial configuration bitstream link: one bit per cycle under a
// valid/ready handshake. The bitstream source is the master and the
// loader is the slave.
interface lut_config_loader_if;
    logic ser_data;
    logic ser_valid;
    logic ser_ready;

    modport master (
        output ser_data,
        output ser_valid,
        input  ser_ready
    );

    modport slave (
        input  ser_data,
        input  ser_valid,
        output ser_ready
    );
endinterface

// File: rtl/lut_config_loader.sv
// LUT configuration loader. Shifts a serial bitstream MSB-first into
// MEM_SIZE-bit words and commits each word to one of NUM_LUTS latch blocks
// with a one-cycle one-hot cen pulse, then reports done.
module lut_config_loader #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2**ADDR_BITS,
    parameter int NUM_LUTS  = 4,
    parameter int IDX_BITS  = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
    input  logic                      cclk,
    input  logic                      rst,
    input  logic                      start,
    lut_config_loader_if.slave        ser,
    output logic [MEM_SIZE-1:0]       config_out,
    output logic [NUM_LUTS-1:0]       cen_out,
    output logic [IDX_BITS-1:0]       lut_idx,
    output logic                      busy,
    output logic                      done
);

    // Bit counter only has to reach MEM_SIZE-1; the COMMIT state marks a full word.
    localparam int CNT_BITS = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_BITS-1:0] bit_cnt;
    logic                ready;
    logic                xfer;
    logic                last_bit;
    logic                last_lut;
    logic [NUM_LUTS-1:0] cen_dec;

    assign ser.ser_ready = ready;

    // A bit moves only when the source offers it and we are shifting.
    assign xfer     = ready && ser.ser_valid;
    assign last_bit = xfer && (bit_cnt == CNT_BITS'(MEM_SIZE - 1));
    assign last_lut = (lut_idx == IDX_BITS'(NUM_LUTS - 1));

    // Decode of the current target into its commit strobe, one bit per latch block.
    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cen_dec
        assign cen_dec[i] = (lut_idx == IDX_BITS'(i));
    end

    // State register.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the two state-decoded outputs (ready, busy).
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (last_bit) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = last_lut ? DONE : SHIFT;
            end
            DONE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: shift register, counters, registered cen strobe and done flag.
    // cen is loaded on the edge that accepts the final bit so it is high
    // exactly for the COMMIT cycle, and cleared by default every other edge.
    always_ff @(posedge cclk) begin
        if (rst) begin
            config_out <= '0;
            cen_out    <= '0;
            lut_idx    <= '0;
            bit_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            cen_out <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        config_out <= '0;
                        lut_idx    <= '0;
                        bit_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        config_out <= {config_out[MEM_SIZE-2:0], ser.ser_data};
                        bit_cnt    <= bit_cnt + CNT_BITS'(1);
                        if (last_bit) begin
                            cen_out <= cen_dec;
                        end
                    end
                end
                COMMIT: begin
                    // config_out is left alone; the next word overwrites every bit.
                    if (last_lut) begin
                        done <= 1'b1;
                    end else begin
                        lut_idx <= lut_idx + IDX_BITS'(1);
                        bit_cnt <= '0;
                    end
                end
                DONE: begin
                    if (start) begin
                        config_out <= '0;
                        lut_idx    <= '0;
                        bit_cnt    <= '0;
                        done       <= 1'b0;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader with MEM_SIZE=16, NUM_LUTS=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_lut_config_loader;

    localparam int ADDR_BITS = 4;
    localparam int MEM_SIZE  = 16;
    localparam int NUM_LUTS  = 2;
    localparam int IDX_BITS  = 1;

    logic                 cclk;
    logic                 rst;
    logic                 start;
    logic [MEM_SIZE-1:0]  config_out;
    logic [NUM_LUTS-1:0]  cen_out;
    logic [IDX_BITS-1:0]  lut_idx;
    logic                 busy;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    lut_config_loader_if ifc ();

    lut_config_loader #(
        .ADDR_BITS (ADDR_BITS),
        .MEM_SIZE  (MEM_SIZE),
        .NUM_LUTS  (NUM_LUTS),
        .IDX_BITS  (IDX_BITS)
    ) dut (
        .cclk       (cclk),
        .rst        (rst),
        .start      (start),
        .ser        (ifc),
        .config_out (config_out),
        .cen_out    (cen_out),
        .lut_idx    (lut_idx),
        .busy       (busy),
        .done       (done)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
        cyc++;
    endtask

    // Send bits w[hi] down to w[lo]; each bit is held until the loader takes it.
    task automatic send_bits(input logic [15:0] w, input int hi, input int lo, input bit stall);
        for (int b = hi; b >= lo; b--) begin
            bit sent;
            int guard;
            sent  = 1'b0;
            guard = 0;
            if (stall) begin
                ifc.ser_valid = 1'b0;
                ifc.ser_data  = ~w[b];
                tick();
                chk("stall_ready", 32'(ifc.ser_ready), 32'd1);
            end
            while (!sent && guard < 8) begin
                ifc.ser_data  = w[b];
                ifc.ser_valid = 1'b1;
                sent = ifc.ser_ready;
                tick();
                guard++;
            end
            chk("bit_taken", 32'(sent), 32'd1);
        end
    endtask

    task automatic commit_chk(input int idx, input logic [15:0] w);
        chk("commit_cen",   32'(cen_out), 32'(1 << idx));
        chk("commit_word",  32'(config_out), 32'(w));
        chk("commit_ready", 32'(ifc.ser_ready), 32'd0);
        chk("commit_busy",  32'(busy), 32'd1);
        chk("commit_idx",   32'(lut_idx), 32'(idx));
        chk("commit_done",  32'(done), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // cen is one-hot or zero, and only nonzero in COMMIT (busy and not ready).
    always @(negedge cclk) begin
        if (!rst) begin
            chk("cen_onehot0", 32'($onehot0(cen_out)), 32'd1);
            chk("cen_only_commit", 32'((cen_out == '0) || (busy && !ifc.ser_ready)), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        ifc.ser_data  = 1'b0;
        ifc.ser_valid = 1'b0;
        tick();
        tick();
        chk("rst_word",  32'(config_out), 32'd0);
        chk("rst_cen",   32'(cen_out), 32'd0);
        chk("rst_idx",   32'(lut_idx), 32'd0);
        chk("rst_ready", 32'(ifc.ser_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(ifc.ser_ready), 32'd0);

        // Basic load, ser_valid held high including through COMMIT.
        cyc = 0;
        pulse_start();
        chk("shift_ready", 32'(ifc.ser_ready), 32'd1);
        chk("shift_busy",  32'(busy), 32'd1);
        send_bits(16'hA5C3, 15, 0, 1'b0);
        chk("commit0_cyc", 32'(cyc), 32'd17);
        commit_chk(0, 16'hA5C3);
        // Offer the next word's first bit during COMMIT; it must not be consumed.
        ifc.ser_data  = 1'b0;
        ifc.ser_valid = 1'b1;
        tick();
        chk("post_commit_word", 32'(config_out), 32'hA5C3);
        chk("post_commit_idx",  32'(lut_idx), 32'd1);
        chk("post_commit_cen",  32'(cen_out), 32'd0);
        send_bits(16'h0F0F, 15, 0, 1'b0);
        chk("commit1_cyc", 32'(cyc), 32'd34);
        commit_chk(1, 16'h0F0F);
        ifc.ser_valid = 1'b0;
        tick();
        chk("done_cyc",   32'(cyc), 32'd35);
        chk("done_flag",  32'(done), 32'd1);
        chk("done_busy",  32'(busy), 32'd0);
        chk("done_ready", 32'(ifc.ser_ready), 32'd0);
        chk("done_word",  32'(config_out), 32'h0F0F);
        tick();
        chk("done_hold",  32'(done), 32'd1);

        // Restart from DONE with ser_valid low on every other cycle.
        cyc = 0;
        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_idx",  32'(lut_idx), 32'd0);
        send_bits(16'hA5C3, 15, 0, 1'b1);
        chk("stall_commit0_cyc", 32'(cyc), 32'd33);
        commit_chk(0, 16'hA5C3);
        ifc.ser_valid = 1'b0;
        tick();
        send_bits(16'h0F0F, 15, 0, 1'b1);
        commit_chk(1, 16'h0F0F);
        tick();
        chk("stall_done", 32'(done), 32'd1);

        // Reset after 7 bits of LUT 1, with ser_valid still high.
        pulse_start();
        send_bits(16'hBEEF, 15, 0, 1'b0);
        commit_chk(0, 16'hBEEF);
        ifc.ser_valid = 1'b0;
        tick();
        send_bits(16'h5A5A, 15, 9, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        ifc.ser_valid = 1'b0;
        chk("mid_rst_cen",   32'(cen_out), 32'd0);
        chk("mid_rst_done",  32'(done), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ifc.ser_ready), 32'd0);
        chk("mid_rst_idx",   32'(lut_idx), 32'd0);
        tick();
        chk("mid_rst_idle",  32'(busy), 32'd0);

        // Fresh load from IDLE with a stray start pulse mid-word.
        pulse_start();
        chk("reload_idx", 32'(lut_idx), 32'd0);
        send_bits(16'h1234, 15, 8, 1'b0);
        ifc.ser_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_busy", 32'(busy), 32'd1);
        chk("ign_start_word", 32'(config_out), 32'h0012);
        chk("ign_start_idx",  32'(lut_idx), 32'd0);
        send_bits(16'h1234, 7, 0, 1'b0);
        commit_chk(0, 16'h1234);
        ifc.ser_valid = 1'b0;
        tick();
        send_bits(16'h8001, 15, 0, 1'b0);
        commit_chk(1, 16'h8001);
        ifc.ser_valid = 1'b0;
        tick();
        chk("final_done", 32'(done), 32'd1);
        chk("final_word", 32'(config_out), 32'h8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
